c17_response_checker: RTL and testbench

Downstream checking stage for the Trojan-inserted c17 netlist. The block samples each applied input vector together with the DUT's N22/N23 response and recomputes the golden (Trojan-free) c17 outputs. It compares the two in a two-stage pipeline, counts vectors and mismatches, and raises a sticky alarm. It also captures the first failing vector/response pair, so a trigger such as the all-ones input is identified in hardware rather than read from a waveform.

---
 rtl/c17_response_checker.sv | 158 +++++++++++++++
 tb/tb_c17_response_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/c17_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : c17_response_checker
//  Description : Recomputes the golden c17 outputs for each applied vector,
//                compares them with the DUT response in a two-stage pipeline,
//                counts vectors/mismatches, raises a sticky alarm and captures
//                the first failing vector/response pair of a run.
//  Revision    : 1.0 - initial release
// ============================================================================
module c17_response_checker #(
    parameter int NUM_VEC      = 32,
    parameter int CNT_W        = 6,
    parameter int ALARM_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [4:0]       vec,
    input  logic             dut_n22,
    input  logic             dut_n23,
    output logic             busy,
    output logic             done,
    output logic             chk_valid,
    output logic             mismatch,
    output logic [5:0]       vec_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             alarm,
    output logic [4:0]       first_fail_vec,
    output logic [1:0]       first_fail_resp
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [5:0]       C_LAST_IDX = 6'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] C_THRESH   = CNT_W'(ALARM_THRESH);

    logic [1:0]       r_state;
    logic [5:0]       r_acc_cnt;
    logic             r_s1_valid;
    logic [4:0]       r_s1_vec;
    logic             r_s1_n22;
    logic             r_s1_n23;
    logic             r_have_fail;

    logic             w_accept;
    logic             w_start_ok;
    logic             w_n10, w_n11, w_n16, w_n19, w_g22, w_g23;
    logic             w_mm;
    logic [CNT_W-1:0] w_mcnt_next;

    assign w_accept   = in_valid && (r_state == ST_RUN) && !clear;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Golden c17 on the stage-1 vector; vec = {N1,N2,N3,N6,N7}
    assign w_n10 = ~(r_s1_vec[4] & r_s1_vec[2]);
    assign w_n11 = ~(r_s1_vec[2] & r_s1_vec[1]);
    assign w_n16 = ~(r_s1_vec[3] & w_n11);
    assign w_n19 = ~(w_n11 & r_s1_vec[0]);
    assign w_g22 = ~(w_n10 & w_n16);
    assign w_g23 = ~(w_n16 & w_n19);

    assign w_mm        = (r_s1_n22 != w_g22) | (r_s1_n23 != w_g23);
    assign w_mcnt_next = (mismatch_cnt == C_CNT_MAX) ? C_CNT_MAX : mismatch_cnt + 1'b1;

    assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done = (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_acc_cnt <= '0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_acc_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_acc_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + 6'd1;
                        if (r_acc_cnt == C_LAST_IDX)
                            r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_vec   <= '0;
            r_s1_n22   <= 1'b0;
            r_s1_n23   <= 1'b0;
            chk_valid  <= 1'b0;
            mismatch   <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
            chk_valid  <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_vec <= vec;
                r_s1_n22 <= dut_n22;
                r_s1_n23 <= dut_n23;
            end
            chk_valid <= r_s1_valid;
            mismatch  <= r_s1_valid & w_mm;
        end
    end

    // Counters update on the same edge that raises chk_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt         <= '0;
            mismatch_cnt    <= '0;
            alarm           <= 1'b0;
            r_have_fail     <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_resp <= '0;
        end else if (clear || w_start_ok) begin
            vec_cnt         <= '0;
            mismatch_cnt    <= '0;
            alarm           <= 1'b0;
            r_have_fail     <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_resp <= '0;
        end else if (r_s1_valid) begin
            vec_cnt <= vec_cnt + 6'd1;
            if (w_mm) begin
                mismatch_cnt <= w_mcnt_next;
                if (w_mcnt_next >= C_THRESH)
                    alarm <= 1'b1;
                if (!r_have_fail) begin
                    r_have_fail     <= 1'b1;
                    first_fail_vec  <= r_s1_vec;
                    first_fail_resp <= {r_s1_n22, r_s1_n23};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_c17_response_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c17_response_checker
//  Description : Directed self-checking bench for c17_response_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c17_response_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, clear, in_valid, n22, n23;
    logic [4:0] vec;
    logic       busy, done, chk_valid, mismatch, alarm;
    logic [5:0] vec_cnt, mismatch_cnt;
    logic [4:0] ffv;
    logic [1:0] ffr;

    logic       b_start, b_clear, b_in_valid, b_n22, b_n23;
    logic [4:0] b_vec;
    logic       b_busy, b_done, b_chk_valid, b_mismatch, b_alarm;
    logic [5:0] b_vec_cnt;
    logic [1:0] b_mismatch_cnt;
    logic [4:0] b_ffv;
    logic [1:0] b_ffr;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    c17_response_checker #(.NUM_VEC(32), .CNT_W(6), .ALARM_THRESH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .vec(vec), .dut_n22(n22), .dut_n23(n23),
        .busy(busy), .done(done), .chk_valid(chk_valid), .mismatch(mismatch),
        .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt), .alarm(alarm),
        .first_fail_vec(ffv), .first_fail_resp(ffr)
    );

    c17_response_checker #(.NUM_VEC(6), .CNT_W(2), .ALARM_THRESH(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .start(b_start), .clear(b_clear),
        .in_valid(b_in_valid), .vec(b_vec), .dut_n22(b_n22), .dut_n23(b_n23),
        .busy(b_busy), .done(b_done), .chk_valid(b_chk_valid), .mismatch(b_mismatch),
        .vec_cnt(b_vec_cnt), .mismatch_cnt(b_mismatch_cnt), .alarm(b_alarm),
        .first_fail_vec(b_ffv), .first_fail_resp(b_ffr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trojan-free c17 response {N22,N23}
    function automatic logic [1:0] c17_ref(input logic [4:0] v);
        logic n10, n11, n16, n19;
        n10 = ~(v[4] & v[2]);
        n11 = ~(v[2] & v[1]);
        n16 = ~(v[3] & n11);
        n19 = ~(n11 & v[0]);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    task automatic send(input logic [4:0] v, input logic [1:0] r);
        vec = v; n22 = r[1]; n23 = r[0]; in_valid = 1'b1;
        tick();
    endtask

    task automatic run_full(input bit trojan);
        logic [1:0] r;
        start = 1'b1; tick(); start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        check("run_vcnt_zero", 32'(vec_cnt), 32'd0);
        check("run_alarm_zero", 32'(alarm), 32'd0);
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            r = c17_ref(5'(i));
            if (trojan && i == 31) r = 2'b00;
            send(5'(i), r);
            pulses += int'(chk_valid);
            if (i == 0) check("lat_no_chk_yet", 32'(chk_valid), 32'd0);
            if (i == 1) check("lat_chk_2cyc", 32'(chk_valid), 32'd1);
            if (i == 31) check("drain_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        pulses += int'(chk_valid);
        check("last_chk_valid", 32'(chk_valid), 32'd1);
        check("last_mismatch", 32'(mismatch), 32'(trojan));
        check("done_flag", 32'(done), 32'd1);
        check("vec_cnt_full", 32'(vec_cnt), 32'd32);
        check("mismatch_cnt", 32'(mismatch_cnt), trojan ? 32'd1 : 32'd0);
        check("alarm", 32'(alarm), 32'(trojan));
        check("ff_vec", 32'(ffv), trojan ? 32'h1f : 32'h0);
        check("ff_resp", 32'(ffr), 32'h0);
        tick();
        check("post_done_chk", 32'(chk_valid), 32'd0);
        check("pulse_count", 32'(pulses), 32'd32);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; clear = 0; in_valid = 0; vec = '0; n22 = 0; n23 = 0;
        b_start = 0; b_clear = 0; b_in_valid = 0; b_vec = '0; b_n22 = 0; b_n23 = 0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vec_cnt", 32'(vec_cnt), 32'd0);
        check("rst_ffv", 32'(ffv), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Clean run, then Trojan-triggering run started from DONE
        run_full(1'b0);
        run_full(1'b1);

        // Clear from DONE, then golden spot checks
        clear = 1'b1; tick(); clear = 1'b0;
        check("clr_done", 32'(done), 32'd0);
        check("clr_alarm", 32'(alarm), 32'd0);
        check("clr_ffv", 32'(ffv), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        send(5'b00000, 2'b00);
        send(5'b00001, 2'b01);
        check("spot0_mm", 32'({chk_valid, mismatch}), 32'b10);
        send(5'b00001, 2'b11);
        check("spot1_mm", 32'({chk_valid, mismatch}), 32'b10);
        in_valid = 1'b0;
        tick();
        check("spot2_mm", 32'({chk_valid, mismatch}), 32'b11);
        check("spot_mcnt", 32'(mismatch_cnt), 32'd1);
        check("spot_ffv", 32'(ffv), 32'h01);
        check("spot_ffr", 32'(ffr), 32'h3);

        // start while busy is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("start_busy_vcnt", 32'(vec_cnt), 32'd3);
        check("start_busy_mcnt", 32'(mismatch_cnt), 32'd1);

        // One vector in flight, then clear together with in_valid
        send(5'b00111, 2'b11);
        clear = 1'b1; vec = 5'b01010; in_valid = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_chk_valid", 32'(chk_valid), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_cnts", 32'({vec_cnt, mismatch_cnt}), 32'd0);
        tick(); tick();
        check("idle_ignore_chk", 32'(chk_valid), 32'd0);
        check("idle_ignore_cnt", 32'(vec_cnt), 32'd0);
        in_valid = 1'b0;

        // Asynchronous reset mid-run
        start = 1'b1; tick(); start = 1'b0;
        send(5'b00001, 2'b11);
        send(5'b00000, 2'b00);
        check("pre_rst_alarm", 32'(alarm), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_outs", 32'({chk_valid, mismatch, alarm, vec_cnt, mismatch_cnt}), 32'd0);
        check("arst_capture", 32'({ffv, ffr}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(); tick(); tick();
        check("post_rst_chk", 32'(chk_valid), 32'd0);
        check("post_rst_cnt", 32'(vec_cnt), 32'd0);
        in_valid = 1'b0;

        // Saturation/threshold instance: every response wrong
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) begin
                b_vec = 5'(i + 3);
                {b_n22, b_n23} = ~c17_ref(5'(i + 3));
                b_in_valid = 1'b1;
            end else begin
                b_in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check("sat_chk", 32'({b_chk_valid, b_mismatch}), 32'b11);
                check("sat_mcnt", 32'(b_mismatch_cnt), (i >= 3) ? 32'd3 : 32'(i));
                check("sat_alarm", 32'(b_alarm), (i >= 3) ? 32'd1 : 32'd0);
            end
        end
        check("sat_done", 32'(b_done), 32'd1);
        check("sat_vcnt", 32'(b_vec_cnt), 32'd6);
        check("sat_ffv", 32'(b_ffv), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
